sprite_loader: RTL and testbench
================================

SPRITE_LOADER -- requirements
Module: sprite_loader

Interface
REQ-001 SHALL have parameter HDR_TAG, default 6'b101000: required value of header byte bits [7:2].
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  byte-stream valid.
REQ-005 SHALL have port in_data  input  8  header or bitmap row byte.
REQ-006 SHALL have port in_ready  output  1  byte accepted on a cycle where in_valid && in_ready.
REQ-007 SHALL have port frame_sync  input  1  one-cycle pulse at frame boundary (vsync-derived).
REQ-008 SHALL have port rd_slot  input  2  sprite slot selected by the renderer side.
REQ-009 SHALL have port rom_addr  input  4  row index driven by the sprite renderer.
REQ-010 SHALL have port rom_bits  output  8  row bits for rd_slot/rom_addr from the front buffer.
REQ-011 SHALL have port pending  output  4  per-slot flag: back buffer loaded, awaiting swap.
REQ-012 SHALL have port hdr_err  output  1  one-cycle pulse on a rejected header byte.

Function
REQ-013 SHALL store 4 slots x 2 buffers x 16 rows x 8 bits; per slot, front_sel[s] marks the displayed buffer.
REQ-014 SHALL drive rom_bits combinationally from buffer front_sel[rd_slot], row rom_addr, with no clock latency, so the renderer can latch it in the cycle after driving rom_addr.
REQ-015 SHALL implement states IDLE, WAIT_SWAP and DATA.
REQ-016 IDLE: in_ready=1; accepted byte with in_data[7:2]==HDR_TAG SHALL latch slot=in_data[1:0], clear row counter, then go to WAIT_SWAP if pending[slot] else DATA.
REQ-017 IDLE: accepted byte with in_data[7:2]!=HDR_TAG SHALL pulse hdr_err next cycle, be discarded, and remain in IDLE.
REQ-018 WAIT_SWAP: in_ready=0; SHALL go to DATA on the cycle after frame_sync clears pending[slot].
REQ-019 DATA: in_ready=1; each accepted byte SHALL be written to buffer ~front_sel[slot], row = row counter; counter increments (4-bit).
REQ-020 On acceptance of row 15, SHALL set pending[slot]=1 and return to IDLE; no header check on data bytes.
REQ-021 in_valid low in DATA SHALL stall without timeout; the row counter holds.
REQ-022 On frame_sync, for every s with pending[s]=1, SHALL toggle front_sel[s] and clear pending[s] in the same cycle.
REQ-023 Row 15 accepted in the same cycle as frame_sync SHALL set pending[slot] and SHALL NOT swap that slot on that frame_sync.
REQ-024 Writes SHALL never target a front buffer; rom_bits for a slot SHALL change only at a swap.
REQ-025 Slots not being loaded SHALL be unaffected by a load or a swap of another slot.

Reset
REQ-026 reset_n low SHALL immediately force state=IDLE, front_sel=0, pending=0, row counter=0, hdr_err=0, in_ready=1 after release.
REQ-027 Bitmap storage SHALL NOT be reset; contents are undefined until loaded and swapped.
REQ-028 Reset mid-DATA SHALL abandon the partial load; the partial rows are in a back buffer and never become visible.

Verification
REQ-029 Header 0xA1, rows 0x00..0x0F, frame_sync -> pending=4'b0010 after last row, then 0000; rd_slot=1, rom_addr=5 -> rom_bits=0x05.
REQ-030 Header 0x55 -> hdr_err pulses 1 cycle, in_ready stays 1, pending unchanged, state IDLE.
REQ-031 Load slot 2 (pending), second header 0xA2 -> in_ready=0 until frame_sync, then 16 rows load into the other buffer; front shows first load until next frame_sync.
REQ-032 Row 15 accepted coincident with frame_sync -> no swap (old rom_bits held), pending set; next frame_sync swaps.
REQ-033 reset_n low after 8 rows of slot 0 -> pending=0, front_sel=0, rom_bits for slot 0 unchanged from pre-reset front contents; new full load succeeds.
REQ-034 Random in_valid gaps during a load -> identical stored rows as gapless load; slots 0,1,3 read back unchanged.

Source files
------------

// File: rtl/sprite_loader.sv
// Double-buffered sprite bitmap store: a header byte picks a slot, 16 row bytes fill its back buffer,
// and frame_sync swaps every loaded slot so the renderer never sees a half-written sprite.
//   state     | meaning
//   IDLE      | waiting for a header byte
//   WAIT_SWAP | target slot still has an unswapped load; hold off until frame_sync
//   DATA      | writing row bytes into the slot's back buffer
`timescale 1ns/1ps
module sprite_loader #(
  parameter logic [5:0] HDR_TAG = 6'b101000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       frame_sync,
  input  logic [1:0] rd_slot,
  input  logic [3:0] rom_addr,
  output logic [7:0] rom_bits,
  output logic [3:0] pending,
  output logic       hdr_err
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_SWAP = 2'd1,
    S_DATA      = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_slot;
  logic [3:0] r_row;
  logic       r_hdr_err;
  logic [3:0] r_front_sel;
  logic [3:0] r_pending;
  logic [3:0] w_front_nxt;
  logic [3:0] w_pending_nxt;
  logic [7:0] r_mem [128];

  logic       w_accept;
  logic       w_hdr_ok;
  logic       w_hdr_take;
  logic       w_wr;
  logic       w_last;
  logic [6:0] w_wr_addr;
  logic [6:0] w_rd_addr;

  assign w_accept   = in_valid && in_ready;
  assign w_hdr_ok   = (in_data[7:2] == HDR_TAG);
  assign w_hdr_take = (r_state == S_IDLE) && w_accept && w_hdr_ok;
  assign w_wr       = (r_state == S_DATA) && w_accept;
  assign w_last     = w_wr && (r_row == 4'hF);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_hdr_take) begin
          w_state_nxt = r_pending[in_data[1:0]] ? S_WAIT_SWAP : S_DATA;
        end
      end
      S_WAIT_SWAP: begin
        // frame_sync this cycle clears the pending flag, so the back buffer is free next cycle
        if (!r_pending[r_slot] || frame_sync) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state != S_WAIT_SWAP);
  end

  // A completing load sets its flag after the swap mask is applied, so it waits for the next frame
  always_comb begin
    w_front_nxt   = r_front_sel;
    w_pending_nxt = r_pending;
    if (frame_sync) begin
      w_front_nxt   = r_front_sel ^ r_pending;
      w_pending_nxt = 4'b0000;
    end
    if (w_last) begin
      w_pending_nxt[r_slot] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_slot      <= 2'd0;
      r_row       <= 4'd0;
      r_hdr_err   <= 1'b0;
      r_front_sel <= 4'b0000;
      r_pending   <= 4'b0000;
    end else begin
      r_hdr_err   <= (r_state == S_IDLE) && w_accept && !w_hdr_ok;
      r_front_sel <= w_front_nxt;
      r_pending   <= w_pending_nxt;
      if (w_hdr_take) begin
        r_slot <= in_data[1:0];
        r_row  <= 4'd0;
      end else if (w_wr) begin
        r_row <= r_row + 4'd1;
      end
    end
  end

  assign w_wr_addr = {r_slot, ~r_front_sel[r_slot], r_row};
  assign w_rd_addr = {rd_slot, r_front_sel[rd_slot], rom_addr};

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[w_wr_addr] <= in_data;
    end
  end

  assign rom_bits = r_mem[w_rd_addr];
  assign pending  = r_pending;
  assign hdr_err  = r_hdr_err;

endmodule

// File: tb/tb_sprite_loader.sv
// Randomized bench for sprite_loader: a slot/buffer-level model tracks which bitmap each
// slot displays, and every visible row the model knows is compared against rom_bits.
`timescale 1ns/1ps
module tb_sprite_loader;
  localparam logic [5:0] TAG = 6'b101000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       frame_sync = 1'b0;
  logic [1:0] rd_slot = 2'd0;
  logic [3:0] rom_addr = 4'd0;
  logic [7:0] rom_bits;
  logic [3:0] pending;
  logic       hdr_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_mem   [4][2][16];
  bit         m_valid [4][2][16];
  bit         m_front [4];
  bit         m_pend  [4];

  sprite_loader #(.HDR_TAG(TAG)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .frame_sync(frame_sync), .rd_slot(rd_slot),
    .rom_addr(rom_addr), .rom_bits(rom_bits), .pending(pending), .hdr_err(hdr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] m_pend_vec();
    logic [3:0] v;
    for (int s = 0; s < 4; s++) v[s] = m_pend[s];
    return v;
  endfunction

  task automatic model_swap();
    for (int s = 0; s < 4; s++) begin
      if (m_pend[s]) begin
        m_front[s] = !m_front[s];
        m_pend[s]  = 1'b0;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_val("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic frame_pulse();
    @(negedge clk);
    frame_sync = 1'b1;
    @(posedge clk);
    #1;
    frame_sync = 1'b0;
    model_swap();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_pending", pending, 0);
    check_val("rst_hdr_err", hdr_err, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int s = 0; s < 4; s++) begin
      m_front[s] = 1'b0;
      m_pend[s]  = 1'b0;
    end
  endtask

  task automatic check_readback(input string tag);
    for (int s = 0; s < 4; s++) begin
      for (int r = 0; r < 16; r++) begin
        if (m_valid[s][m_front[s]][r]) begin
          @(negedge clk);
          rd_slot  = 2'(s);
          rom_addr = 4'(r);
          #1;
          check_val(tag, rom_bits, m_mem[s][m_front[s]][r]);
        end
      end
    end
  endtask

  task automatic do_load(input logic [1:0] slot, input logic [7:0] rows [16],
                         input int max_gap, input bit coincide);
    send_byte({TAG, slot}, 0);
    if (m_pend[slot]) begin
      check_val("wait_swap_ready", in_ready, 0);
      repeat (3) @(negedge clk);
      check_val("wait_swap_hold", in_ready, 0);
      frame_pulse();
      check_val("wait_swap_release", in_ready, 1);
      check_val("wait_swap_pend_clr", pending[slot], 0);
    end
    for (int r = 0; r < 15; r++) send_byte(rows[r], $urandom_range(0, max_gap));
    if (coincide) begin
      @(negedge clk);
      in_valid   = 1'b1;
      in_data    = rows[15];
      frame_sync = 1'b1;
      check_val("coincide_ready", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid   = 1'b0;
      frame_sync = 1'b0;
      model_swap();
    end else begin
      send_byte(rows[15], $urandom_range(0, max_gap));
    end
    for (int r = 0; r < 16; r++) begin
      m_mem[slot][!m_front[slot]][r]   = rows[r];
      m_valid[slot][!m_front[slot]][r] = 1'b1;
    end
    m_pend[slot] = 1'b1;
    check_val("load_pending", pending, m_pend_vec());
    check_val("load_idle_ready", in_ready, 1);
  endtask

  task automatic rand_rows(output logic [7:0] rows [16]);
    for (int r = 0; r < 16; r++) rows[r] = 8'($urandom);
  endtask

  task automatic bad_header(input logic [7:0] b);
    send_byte(b, 0);
    check_val("hdr_err_pulse", hdr_err, 1);
    check_val("hdr_err_ready", in_ready, 1);
    check_val("hdr_err_pending", pending, m_pend_vec());
    @(posedge clk);
    #1;
    check_val("hdr_err_one_cycle", hdr_err, 0);
    check_val("hdr_err_idle", in_ready, 1);
  endtask

  initial begin
    logic [7:0] rows [16];
    logic [7:0] rows_b [16];
    logic [7:0] b;

    repeat (3) @(negedge clk);
    #1;
    check_val("por_in_ready", in_ready, 1);
    check_val("por_pending", pending, 0);
    check_val("por_hdr_err", hdr_err, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Slot 1 loaded with its row index, then swapped into view
    for (int r = 0; r < 16; r++) rows[r] = 8'(r);
    do_load(2'd1, rows, 0, 1'b0);
    check_val("basic_pending", pending, 4'b0010);
    frame_pulse();
    check_val("basic_pending_clr", pending, 4'b0000);
    @(negedge clk);
    rd_slot  = 2'd1;
    rom_addr = 4'd5;
    #1;
    check_val("basic_rom_bits", rom_bits, 8'h05);

    bad_header(8'h55);

    // Back-to-back loads of slot 2 stall until the first is swapped in
    rand_rows(rows);
    do_load(2'd2, rows, 1, 1'b0);
    rand_rows(rows_b);
    do_load(2'd2, rows_b, 1, 1'b0);
    check_readback("slot2_first_visible");
    frame_pulse();
    check_readback("slot2_second_visible");

    // Row 15 coincident with frame_sync: slot 3 keeps its old image, slot 1 swaps
    rand_rows(rows);
    do_load(2'd3, rows, 0, 1'b0);
    frame_pulse();
    rand_rows(rows);
    do_load(2'd1, rows, 0, 1'b0);
    rand_rows(rows_b);
    do_load(2'd3, rows_b, 0, 1'b1);
    check_val("coincide_pending", pending, 4'b1000);
    check_readback("coincide_old_held");
    frame_pulse();
    check_readback("coincide_next_swap");

    // Reset in the middle of a slot 0 load; slot 0 front is buffer 0 beforehand
    rand_rows(rows);
    do_load(2'd0, rows, 0, 1'b0);
    frame_pulse();
    rand_rows(rows);
    do_load(2'd0, rows, 0, 1'b0);
    frame_pulse();
    check_readback("pre_reset");
    rand_rows(rows);
    send_byte({TAG, 2'd0}, 0);
    for (int r = 0; r < 8; r++) begin
      send_byte(rows[r], 0);
      m_mem[0][!m_front[0]][r]   = rows[r];
      m_valid[0][!m_front[0]][r] = 1'b1;
    end
    apply_reset();
    check_val("post_reset_pending", pending, 0);
    check_readback("post_reset");
    rand_rows(rows);
    do_load(2'd0, rows, 2, 1'b0);
    frame_pulse();
    check_readback("reload_after_reset");

    // Gapped load of slot 2 must store exactly what a gapless load would
    rand_rows(rows);
    do_load(2'd2, rows, 5, 1'b0);
    frame_pulse();
    check_readback("gapped_load");

    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          b = 8'($urandom);
          while (b[7:2] == TAG) b = 8'($urandom);
          bad_header(b);
        end
        1: frame_pulse();
        default: begin
          rand_rows(rows);
          do_load(2'($urandom_range(0, 3)), rows, $urandom_range(0, 3),
                  ($urandom_range(0, 3) == 0));
        end
      endcase
      check_val("rand_pending", pending, m_pend_vec());
      if (it % 4 == 3) check_readback("rand_readback");
    end
    frame_pulse();
    check_readback("final_readback");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
